cricket_ball_tracker: RTL
=========================

// Module: cricket_ball_tracker
// PURPOSE
//   Generalised per-team legal-ball counter and LED display driver for the cricket game.
//   Counts legal deliveries for NUM_TEAMS teams and tracks overs and ball-in-over.
//   Raises a per-team innings-over flag when the ball limit is reached.
//   Drives the LED bank in raw or over.ball mode; shows a scrolling pattern on game over.
// PARAMETERS
//   NUM_TEAMS      2    number of batting teams (>=2)
//   BALL_W         7    width of each team's legal-ball counter
//   LED_W          16   LED bank width (even)
//   BALLS_PER_OVER 6    legal balls per over
//   MAX_OVERS      5    overs per innings; BALL_LIMIT=MAX_OVERS*BALLS_PER_OVER, must be < 2**BALL_W
//   WIDE_CODE      13   lfsr_out value meaning wide (not a legal ball)
//   NOBALL_CODE    14   lfsr_out value meaning no-ball (not a legal ball)
//   SCROLL_DIV     25000000  clk_fpga cycles per scroll step (>=1)
// PORTS
//   clk_fpga      in   1                   system clock
//   reset         in   1                   asynchronous, active-high reset
//   team_sel      in   TEAM_W=$clog2(NUM_TEAMS)  index of batting team
//   delivery      in   1                   one-cycle strobe, one ball bowled
//   lfsr_out      in   4                   outcome code of this delivery
//   game_over     in   1                   level; game finished
//   disp_mode     in   1                   0=raw ball count, 1=over.ball
//   leds          out  LED_W               LED bank
//   balls_flat    out  NUM_TEAMS*BALL_W    legal-ball counts, team t at [t*BALL_W +: BALL_W]
//   innings_over  out  NUM_TEAMS           per-team innings complete
//   over_done     out  1                   one-cycle pulse on completion of an over
//   free_hit      out  1                   next delivery is a free hit (FREE_HIT_EN only)
// BEHAVIOUR
//   - Reset: all counters, leds, innings_over, over_done, free_hit = 0; scroll pattern = 1.
//   - Accepted delivery: delivery=1, game_over=0, team_sel<NUM_TEAMS, innings_over[team_sel]=0.
//     All other deliveries are ignored (no state change).
//   - Legal ball: accepted delivery with lfsr_out not WIDE_CODE/NOBALL_CODE. It increments
//     the selected team's ball count and ball_in_over at the same edge.
//   - ball_in_over wraps BALLS_PER_OVER-1 -> 0 and increments over count.
//     over_done pulses high for the cycle following that edge.
//   - Ball count reaching BALL_LIMIT sets innings_over[t] at the same edge; the count then holds.
//     innings_over clears only on reset.
//   - leds is registered. It shows post-update values: the LEDs equal the new count in the
//     cycle after the delivery edge, with no stale-by-one lag.
//   - Display priority:
//     - game_over: scroller pattern.
//     - team_sel>=NUM_TEAMS: 0.
//     - disp_mode=0: zero-extended ball count of team_sel.
//     - disp_mode=1: {over[LED_W/2-1:0], ball_in_over[LED_W/2-1:0]}, zero-extended.
//   - Scroller: free-running one-hot rotate-left across LED_W, one step every SCROLL_DIV cycles.
//     Runs regardless of game_over.
//   - game_over asserted with delivery in the same cycle: game_over wins, and the delivery is dropped.
//   - team_sel change takes effect on leds the next cycle; counters of other teams are untouched.
//   - Reset asserted mid-operation clears everything immediately (asynchronous).
// CONFIGURATION
//   FREE_HIT_EN defined:
//     - An accepted NOBALL_CODE delivery sets free_hit.
//     - The next legal ball, or any team_sel change, clears free_hit.
//     - A wide leaves free_hit set.
//   FREE_HIT_EN undefined: free_hit is tied to 0 and no flag register exists.
// STRUCTURE
//   Shared package cricket_pkg: outcome code constants (WIDE_CODE, NOBALL_CODE),
//   display-mode encodings, and the BALL_LIMIT function.
//   Sub-module led_scroller (params LED_W, SCROLL_DIV; ports clk_fpga, reset, pattern).
//   Per-team counters are generated with a generate-for over NUM_TEAMS.
// TESTING
//   1. Reset, team_sel=0, 3 deliveries with lfsr_out=2 -> balls team0=3, leds=16'h0003, team1=0.
//   2. Team 0, deliveries with codes 13, 14, 5 -> team0 count +1 only.
//      With FREE_HIT_EN: free_hit=1 after the code-14 delivery, 0 after the code-5 delivery.
//   3. 6 legal balls, disp_mode=1 -> over_done pulses once; leds=16'h0100.
//   4. 30 legal balls (defaults) -> innings_over[0]=1, count=30.
//      A 31st delivery leaves count=30 and produces no over_done.
//   5. game_over=1 with a simultaneous delivery -> counts unchanged; leds=scroller.
//      With SCROLL_DIV=4, leds steps 1,2,4,... every 4 cycles.
//   6. Reset pulsed mid-over (team1 at 4 balls) -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/cricket_pkg.sv
// Shared constants and helpers for the cricket ball tracker: outcome codes,
// display-mode encodings and the innings ball-limit function.
package cricket_pkg;

  localparam logic [3:0] WIDE_CODE   = 4'd13;
  localparam logic [3:0] NOBALL_CODE = 4'd14;

  typedef enum logic {
    DISP_RAW       = 1'b0,
    DISP_OVER_BALL = 1'b1
  } disp_mode_e;

  function automatic int ball_limit(input int max_overs, input int balls_per_over);
    return max_overs * balls_per_over;
  endfunction

endpackage

// File: rtl/led_scroller.sv
// Free-running one-hot LED scroller: rotates left one position every
// SCROLL_DIV clock cycles, starting from bit 0 after reset.
module led_scroller #(
  parameter int LED_W      = 16,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic             clk_fpga,
  input  logic             reset,
  output logic [LED_W-1:0] pattern
);

  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pattern <= LED_W'(1);
    end else if (div_cnt == CNT_W'(SCROLL_DIV - 1)) begin
      div_cnt <= '0;
      pattern <= {pattern[LED_W-2:0], pattern[LED_W-1]};
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cricket_ball_tracker.sv
// Per-team legal-ball counter, over tracker and LED display driver.
// Optional free-hit flag is built when the FREE_HIT_EN macro is defined.
module cricket_ball_tracker #(
  parameter int         NUM_TEAMS      = 2,
  parameter int         BALL_W         = 7,
  parameter int         LED_W          = 16,
  parameter int         BALLS_PER_OVER = 6,
  parameter int         MAX_OVERS      = 5,
  parameter logic [3:0] WIDE_CODE      = cricket_pkg::WIDE_CODE,
  parameter logic [3:0] NOBALL_CODE    = cricket_pkg::NOBALL_CODE,
  parameter int         SCROLL_DIV     = 25000000,
  localparam int        TEAM_W         = (NUM_TEAMS > 1) ? $clog2(NUM_TEAMS) : 1
) (
  input  logic                        clk_fpga,
  input  logic                        reset,
  input  logic [TEAM_W-1:0]           team_sel,
  input  logic                        delivery,
  input  logic [3:0]                  lfsr_out,
  input  logic                        game_over,
  input  logic                        disp_mode,
  output logic [LED_W-1:0]            leds,
  output logic [NUM_TEAMS*BALL_W-1:0] balls_flat,
  output logic [NUM_TEAMS-1:0]        innings_over,
  output logic                        over_done,
  output logic                        free_hit
);

  import cricket_pkg::*;

  localparam int BALL_LIMIT = ball_limit(MAX_OVERS, BALLS_PER_OVER);
  localparam int HALF       = LED_W / 2;

  logic                        team_valid;
  logic                        base_ok;
  logic                        legal_code;
  logic [NUM_TEAMS-1:0]        acc_vec;
  logic [NUM_TEAMS-1:0]        wrap_vec;
  logic [NUM_TEAMS*BALL_W-1:0] balls_nx;
  logic [NUM_TEAMS*BALL_W-1:0] overs_nx;
  logic [NUM_TEAMS*BALL_W-1:0] bio_nx;
  logic [BALL_W-1:0]           balls_sel;
  logic [BALL_W-1:0]           overs_sel;
  logic [BALL_W-1:0]           bio_sel;
  logic [HALF-1:0]             ov_h;
  logic [HALF-1:0]             bio_h;
  logic [LED_W-1:0]            pattern;
  logic [LED_W-1:0]            leds_n;

  assign team_valid = int'(team_sel) < NUM_TEAMS;
  assign base_ok    = delivery && !game_over && team_valid;
  assign legal_code = (lfsr_out != WIDE_CODE) && (lfsr_out != NOBALL_CODE);

  for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
    logic [BALL_W-1:0] balls, bio, overs;
    logic [BALL_W-1:0] balls_n, bio_n, overs_n;
    logic              done, done_n;
    logic              acc, hit, at_wrap;

    assign acc     = base_ok && (int'(team_sel) == t) && !done;
    assign hit     = acc && legal_code;
    assign at_wrap = (bio == BALL_W'(BALLS_PER_OVER - 1));

    always_comb begin
      balls_n = balls;
      bio_n   = bio;
      overs_n = overs;
      done_n  = done;
      if (hit) begin
        balls_n = balls + 1'b1;
        if (at_wrap) begin
          bio_n   = '0;
          overs_n = overs + 1'b1;
        end else begin
          bio_n   = bio + 1'b1;
        end
        done_n = (balls_n == BALL_W'(BALL_LIMIT));
      end
    end

    always_ff @(posedge clk_fpga or posedge reset) begin
      if (reset) begin
        balls <= '0;
        bio   <= '0;
        overs <= '0;
        done  <= 1'b0;
      end else begin
        balls <= balls_n;
        bio   <= bio_n;
        overs <= overs_n;
        done  <= done_n;
      end
    end

    assign acc_vec[t]                     = acc;
    assign wrap_vec[t]                    = hit && at_wrap;
    assign balls_nx[t*BALL_W +: BALL_W]   = balls_n;
    assign overs_nx[t*BALL_W +: BALL_W]   = overs_n;
    assign bio_nx[t*BALL_W +: BALL_W]     = bio_n;
    assign balls_flat[t*BALL_W +: BALL_W] = balls;
    assign innings_over[t]                = done;
  end

  // Display is fed from next-state values so leds never lag the counters.
  always_comb begin
    balls_sel = '0;
    overs_sel = '0;
    bio_sel   = '0;
    for (int unsigned t = 0; t < NUM_TEAMS; t++) begin
      if (int'(team_sel) == int'(t)) begin
        balls_sel = balls_nx[t*BALL_W +: BALL_W];
        overs_sel = overs_nx[t*BALL_W +: BALL_W];
        bio_sel   = bio_nx[t*BALL_W +: BALL_W];
      end
    end
  end

  assign ov_h  = HALF'(overs_sel);
  assign bio_h = HALF'(bio_sel);

  always_comb begin
    leds_n = '0;
    if (game_over)
      leds_n = pattern;
    else if (!team_valid)
      leds_n = '0;
    else if (disp_mode == DISP_OVER_BALL)
      leds_n = {ov_h, bio_h};
    else
      leds_n = LED_W'(balls_sel);
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      leds      <= '0;
      over_done <= 1'b0;
    end else begin
      leds      <= leds_n;
      over_done <= |wrap_vec;
    end
  end

`ifdef FREE_HIT_EN
  logic              fh_q;
  logic [TEAM_W-1:0] team_prev;

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      fh_q      <= 1'b0;
      team_prev <= '0;
    end else begin
      team_prev <= team_sel;
      if ((|acc_vec) && (lfsr_out == NOBALL_CODE))
        fh_q <= 1'b1;
      else if (((|acc_vec) && legal_code) || (team_sel != team_prev))
        fh_q <= 1'b0;
    end
  end

  assign free_hit = fh_q;
`else
  assign free_hit = 1'b0;
`endif

  led_scroller #(
    .LED_W      (LED_W),
    .SCROLL_DIV (SCROLL_DIV)
  ) u_scroller (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .pattern  (pattern)
  );

endmodule
